vram_arbiter: RTL and testbench

Shares a single-port synchronous video RAM between three requesters: the display fetch path (driven by the renderer during active video), a clear engine that fills the whole frame with one colour, and a generic writer port with a valid/ready handshake. Display reads always win, so scan-out never misses a pixel. Writes and clears use the remaining cycles. The block sits between the VGA renderer and the frame-buffer RAM, in the 50 MHz `clk` domain.

---
 rtl/vram_arbiter_if.sv | 33 +++
 rtl/vram_arbiter.sv | 136 +++++++++++++
 tb/tb_vram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Requester and RAM-side signal bundle for vram_arbiter.
// slave = arbiter side; master = renderer/clear/writer clients and RAM.
interface vram_arbiter_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 3
);
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic [DATA_W-1:0] disp_data;
   logic              disp_valid;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              clr_start;
   logic [DATA_W-1:0] clr_data;
   logic              clr_busy;
   logic              clr_done;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, clr_start, clr_data, ram_rdata,
      output disp_data, disp_valid, wr_ready, clr_busy, clr_done, ram_addr, ram_we, ram_wdata
   );

   modport master (
      output disp_req, disp_addr, wr_valid, wr_addr, wr_data, clr_start, clr_data, ram_rdata,
      input  disp_data, disp_valid, wr_ready, clr_busy, clr_done, ram_addr, ram_we, ram_wdata
   );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display read > buffered write > clear fill > direct write (VRAM_WR_BUF_EN adds a 1-entry write buffer).
// Latency: disp_data 3 cycles after disp_req; any issued write reaches the RAM port the cycle after arbitration.
// Backpressure: wr_ready low during a clear, and while disp_req is high (no buffer) or the buffer is full.
module vram_arbiter #(
   parameter int DEPTH  = 19200,
   parameter int ADDR_W = 15,
   parameter int DATA_W = 3
) (
   input  logic          clk,
   input  logic          rst,
   vram_arbiter_if.slave bus
);
`ifdef VRAM_WR_BUF_EN
   localparam bit BUF_EN = 1'b1;
`else
   localparam bit BUF_EN = 1'b0;
`endif
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {S_IDLE, S_CLEAR} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic [DATA_W-1:0] clr_col_q, clr_col_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic              ram_we_q, ram_we_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              clr_done_q, clr_done_d;
   logic              buf_full_q, buf_full_d;
   logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
   logic [DATA_W-1:0] buf_data_q, buf_data_d;
   logic              rd_p1_q, rd_p2_q;
   logic [DATA_W-1:0] disp_data_q;
   logic              disp_valid_q;
   logic              wr_ready;
   logic              wr_fire;

`ifdef VRAM_WR_BUF_EN
   assign wr_ready = !buf_full_q && (state_q != S_CLEAR) && !rst;
`else
   assign wr_ready = !bus.disp_req && (state_q != S_CLEAR) && !rst;
`endif
   assign wr_fire = bus.wr_valid && wr_ready;

   always_comb begin
      state_d     = state_q;
      clr_addr_d  = clr_addr_q;
      clr_col_d   = clr_col_q;
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      clr_done_d  = 1'b0;
      buf_full_d  = buf_full_q;
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;

      if (state_q == S_IDLE && bus.clr_start) begin
         state_d    = S_CLEAR;
         clr_addr_d = '0;
         clr_col_d  = bus.clr_data;
      end

      if (bus.disp_req) begin
         ram_addr_d = bus.disp_addr;
         // A write accepted alongside a read parks in the buffer.
         if (BUF_EN && wr_fire) begin
            buf_full_d = 1'b1;
            buf_addr_d = bus.wr_addr;
            buf_data_d = bus.wr_data;
         end
      end else if (buf_full_q) begin
         ram_addr_d  = buf_addr_q;
         ram_wdata_d = buf_data_q;
         ram_we_d    = 1'b1;
         buf_full_d  = 1'b0;
      end else if (state_q == S_CLEAR) begin
         ram_addr_d  = clr_addr_q;
         ram_wdata_d = clr_col_q;
         ram_we_d    = 1'b1;
         if (clr_addr_q == LAST_ADDR) begin
            state_d    = S_IDLE;
            clr_done_d = 1'b1;
         end else begin
            clr_addr_d = clr_addr_q + 1'b1;
         end
      end else if (wr_fire) begin
         ram_addr_d  = bus.wr_addr;
         ram_wdata_d = bus.wr_data;
         ram_we_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         clr_addr_q   <= '0;
         clr_col_q    <= '0;
         ram_addr_q   <= '0;
         ram_we_q     <= 1'b0;
         ram_wdata_q  <= '0;
         clr_done_q   <= 1'b0;
         buf_full_q   <= 1'b0;
         buf_addr_q   <= '0;
         buf_data_q   <= '0;
         rd_p1_q      <= 1'b0;
         rd_p2_q      <= 1'b0;
         disp_data_q  <= '0;
         disp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_addr_q   <= clr_addr_d;
         clr_col_q    <= clr_col_d;
         ram_addr_q   <= ram_addr_d;
         ram_we_q     <= ram_we_d;
         ram_wdata_q  <= ram_wdata_d;
         clr_done_q   <= clr_done_d;
         buf_full_q   <= buf_full_d;
         buf_addr_q   <= buf_addr_d;
         buf_data_q   <= buf_data_d;
         // Read pipeline: address out, RAM access, capture.
         rd_p1_q      <= bus.disp_req;
         rd_p2_q      <= rd_p1_q;
         disp_valid_q <= rd_p2_q;
         if (rd_p2_q) disp_data_q <= bus.ram_rdata;
      end
   end

   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_we     = ram_we_q;
   assign bus.ram_wdata  = ram_wdata_q;
   assign bus.disp_data  = disp_data_q;
   assign bus.disp_valid = disp_valid_q;
   assign bus.wr_ready   = wr_ready;
   assign bus.clr_busy   = (state_q == S_CLEAR);
   assign bus.clr_done   = clr_done_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: vector table, read scoreboard, clear/reset sequences.
module tb_vram_arbiter;
   localparam int DEPTH = 19200;
   localparam int AW    = 15;
   localparam int DW    = 3;
`ifdef VRAM_WR_BUF_EN
   localparam logic RD_RDY  = 1'b1;
   localparam int   ACC_EXP = 0;
`else
   localparam logic RD_RDY  = 1'b0;
   localparam int   ACC_EXP = 4;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   done_total = 0;
   int   we_total = 0;

   vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   vram_arbiter #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
   end

   typedef struct { logic [DW-1:0] d; int c; } sb_t;
   sb_t sb_q[$];
   sb_t e;
   logic [DW-1:0] exp_mem [DEPTH];

   always @(negedge clk) begin
      if (bus.disp_valid) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL disp_spurious: disp_valid=1 data %0b at cycle %0d, expected no valid", bus.disp_data, cyc);
         end else begin
            e = sb_q.pop_front();
            if (bus.disp_data !== e.d || cyc != e.c + 3) begin
               errors++;
               $display("FAIL disp_read: data %0b cycle %0d, expected data %0b cycle %0d", bus.disp_data, cyc, e.d, e.c + 3);
            end
         end
      end
      if (bus.clr_done) done_total++;
      if (bus.ram_we) we_total++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [DW-1:0] d);
      sb_q.push_back('{d: d, c: cyc});
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      tick();
      bus.disp_req = 1'b1; bus.disp_addr = a;
      @(negedge clk);
      push_exp(exp_mem[a]);
      tick();
      bus.disp_req = 1'b0;
      repeat (4) tick();
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      tick();
      bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         if (bus.wr_ready) break;
         n++;
      end
      tick();
      bus.wr_valid = 1'b0;
      chk("wr_accept", 32'(n < 200), 1);
      if (n < 200) exp_mem[a] = d;
   endtask

   typedef struct {
      logic rd; logic wv; logic [AW-1:0] addr; logic [DW-1:0] dat;
      logic e_rdy; logic e_we; logic [AW-1:0] e_addr;
   } vec_t;
   vec_t vt[12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int n, acc, xfer, d0, w0;
      bus.disp_req = 0; bus.disp_addr = '0; bus.wr_valid = 0; bus.wr_addr = '0;
      bus.wr_data = '0; bus.clr_start = 0; bus.clr_data = '0;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;

      for (int i = 0; i < 8; i++) vt[i] = '{1'b0, 1'b1, AW'(i), DW'(i), 1'b1, 1'b1, AW'(i)};
      vt[8]  = '{1'b1, 1'b0, 15'd3,   3'd0, RD_RDY, 1'b0, 15'd3};
      vt[9]  = '{1'b0, 1'b0, 15'd0,   3'd0, 1'b1,   1'b0, 15'd3};
      vt[10] = '{1'b0, 1'b1, 15'd100, 3'd6, 1'b1,   1'b1, 15'd100};
      vt[11] = '{1'b1, 1'b0, 15'd100, 3'd0, RD_RDY, 1'b0, 15'd100};

      // Reset values.
      @(negedge clk);
      chk("rst_ram_addr", 32'(bus.ram_addr), 0);
      chk("rst_ram_we", 32'(bus.ram_we), 0);
      chk("rst_ram_wdata", 32'(bus.ram_wdata), 0);
      chk("rst_disp_data", 32'(bus.disp_data), 0);
      chk("rst_disp_valid", 32'(bus.disp_valid), 0);
      chk("rst_clr_busy", 32'(bus.clr_busy), 0);
      chk("rst_clr_done", 32'(bus.clr_done), 0);
      chk("rst_wr_ready", 32'(bus.wr_ready), 0);
      tick();
      rst = 1'b0;

      // Vector table: one stimulus cycle, one idle cycle to observe the issue.
      for (int i = 0; i < 12; i++) begin
         tick();
         bus.disp_req = vt[i].rd; bus.disp_addr = vt[i].addr;
         bus.wr_valid = vt[i].wv; bus.wr_addr = vt[i].addr; bus.wr_data = vt[i].dat;
         @(negedge clk);
         chk($sformatf("vec%0d_rdy", i), 32'(bus.wr_ready), 32'(vt[i].e_rdy));
         if (vt[i].rd) push_exp(exp_mem[vt[i].addr]);
         if (vt[i].wv && vt[i].e_rdy) exp_mem[vt[i].addr] = vt[i].dat;
         tick();
         bus.disp_req = 0; bus.wr_valid = 0;
         @(negedge clk);
         chk($sformatf("vec%0d_we", i), 32'(bus.ram_we), 32'(vt[i].e_we));
         chk($sformatf("vec%0d_addr", i), 32'(bus.ram_addr), 32'(vt[i].e_addr));
         if (vt[i].e_we) chk($sformatf("vec%0d_wdata", i), 32'(bus.ram_wdata), 32'(vt[i].dat));
      end
      repeat (4) tick();

      // Back-to-back read stream 0..7.
      for (int k = 0; k < 8; k++) begin
         tick();
         bus.disp_req = 1'b1; bus.disp_addr = AW'(k);
         push_exp(exp_mem[k]);
      end
      tick();
      bus.disp_req = 1'b0;
      repeat (5) tick();
      chk("rd_stream_drained", 32'(sb_q.size()), 0);

      // Write/read conflict on address 5.
      do_write(15'd5, 3'b000);
      acc = -1;
      for (int k = 0; k < 8; k++) begin
         tick();
         bus.disp_req = (k < 4); bus.disp_addr = AW'(k);
         bus.wr_valid = (acc < 0); bus.wr_addr = 15'd5; bus.wr_data = 3'b101;
         @(negedge clk);
         if (bus.disp_req) push_exp(exp_mem[k]);
         if (bus.wr_valid && bus.wr_ready && acc < 0) acc = k;
      end
      tick();
      bus.disp_req = 0; bus.wr_valid = 0;
      chk("conflict_accept_cycle", 32'(acc), 32'(ACC_EXP));
      exp_mem[5] = 3'b101;
      repeat (3) tick();
      do_read(15'd5);

      // Full clear with an ignored second start.
      d0 = done_total; w0 = we_total; n = 0;
      tick();
      bus.clr_start = 1'b1; bus.clr_data = 3'b010;
      tick();
      bus.clr_start = 1'b0; bus.clr_data = 3'b000;
      @(negedge clk);
      chk("clr_busy_rise", 32'(bus.clr_busy), 1);
      n = 1;
      for (int k = 0; k < 50000; k++) begin
         tick();
         bus.clr_start = (k == 48);
         if (k == 48) bus.clr_data = 3'b100;
         @(negedge clk);
         if (!bus.clr_busy) break;
         n++;
      end
      chk("clr_done_at_fall", 32'(bus.clr_done), 1);
      chk("clr_busy_cycles", 32'(n), DEPTH);
      tick();
      @(negedge clk);
      chk("clr_done_pulse_width", 32'(bus.clr_done), 0);
      chk("clr_done_once", 32'(done_total - d0), 1);
      chk("clr_write_cycles", 32'(we_total - w0), DEPTH);
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 3'b010;
      do_read(15'd0);
      do_read(15'd9600);
      do_read(15'd19199);
      chk("clr_reads_drained", 32'(sb_q.size()), 0);

      // Reset in the middle of a clear.
      tick();
      bus.clr_start = 1'b1; bus.clr_data = 3'b111;
      tick();
      bus.clr_start = 1'b0;
      n = 0;
      while (n < 500) begin
         @(negedge clk);
         if (bus.ram_we && bus.ram_addr == 15'd100) break;
         n++;
      end
      chk("midclr_reached_100", 32'(n < 500), 1);
      d0 = done_total;
      #1 rst = 1'b1;
      #1;
      chk("midrst_ram_addr", 32'(bus.ram_addr), 0);
      chk("midrst_ram_we", 32'(bus.ram_we), 0);
      chk("midrst_ram_wdata", 32'(bus.ram_wdata), 0);
      chk("midrst_disp_data", 32'(bus.disp_data), 0);
      chk("midrst_clr_busy", 32'(bus.clr_busy), 0);
      chk("midrst_wr_ready", 32'(bus.wr_ready), 0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (30) tick();
      @(negedge clk);
      chk("midrst_idle_busy", 32'(bus.clr_busy), 0);
      chk("midrst_idle_ready", 32'(bus.wr_ready), 1);
      chk("midrst_no_done", 32'(done_total - d0), 0);

      // Clear under 50% display load, with a write racing the start.
      d0 = done_total; n = 0; xfer = 0;
      tick();
      bus.clr_start = 1'b1; bus.clr_data = 3'b110;
      bus.wr_valid = 1'b1; bus.wr_addr = 15'd7; bus.wr_data = 3'b110;
      @(negedge clk);
      chk("simul_wr_ready", 32'(bus.wr_ready), 1);
      tick();
      bus.clr_start = 1'b0; bus.disp_req = 1'b1; bus.disp_addr = 15'd19199;
      for (int k = 0; k < 50000; k++) begin
         @(negedge clk);
         if (k == 0) begin
            chk("simul_wr_we", 32'(bus.ram_we), 1);
            chk("simul_wr_addr", 32'(bus.ram_addr), 7);
         end
         if (!bus.clr_busy) begin
            if (bus.disp_req) push_exp(3'b110);
            break;
         end
         n++;
         if (bus.wr_valid && bus.wr_ready) xfer++;
         if (bus.disp_req) push_exp(3'b010);
         tick();
         bus.disp_req = !bus.disp_req;
      end
      tick();
      bus.disp_req = 0; bus.wr_valid = 0;
      chk("load_clr_cycles", 32'(n >= 2 * DEPTH - 2 && n <= 2 * DEPTH + 2), 1);
      chk("load_clr_no_wr", 32'(xfer), 0);
      repeat (6) tick();
      chk("load_clr_done_once", 32'(done_total - d0), 1);
      chk("load_reads_drained", 32'(sb_q.size()), 0);
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 3'b110;
      do_read(15'd0);
      do_read(15'd19199);
      repeat (2) tick();
      chk("final_drained", 32'(sb_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
